// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam logic        WRITE_BIT  = 1'b1;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned EDGE_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer: emits alternating one-cycle rise/fall strobes every CLK_DIV cycles while enabled.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  // Strobes are decoded one count early so they are registered yet land on the wrap cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt       <= '0;
      phase     <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      rise_tick <= (cnt == CNT_PRE) && !phase;
      fall_tick <= (cnt == CNT_PRE) && phase;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator that serialises one {write, addr, data} frame per valid/ready request.
module spi_reg_writer
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  output logic              busy,
  output logic              done
);

  localparam logic [EDGE_W-1:0] LAST_FALL_PRE = EDGE_W'(2 * FRAME_BITS - 2);

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [EDGE_W-1:0]       edge_cnt;
  logic                    rise_tick;
  logic                    fall_tick;
  logic                    gen_en;
  logic                    gen_clr;

  assign gen_clr = (state == IDLE);
  assign gen_en  = (state != IDLE);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (gen_en),
    .clr       (gen_clr),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Every phase boundary (setup, edges, hold, gap) lands on a half-period strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ncs       <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      shreg     <= '0;
      edge_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            shreg     <= {WRITE_BIT, req_addr, req_data};
            copi      <= WRITE_BIT;
            ncs       <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          copi <= shreg[FRAME_BITS-1];
          if (rise_tick) begin
            sclk     <= 1'b1;
            edge_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            sclk     <= 1'b1;
            edge_cnt <= edge_cnt + EDGE_W'(1);
          end else if (fall_tick) begin
            sclk     <= 1'b0;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (edge_cnt == LAST_FALL_PRE) begin
              state <= HOLD;
            end else begin
              shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
              copi  <= shreg[FRAME_BITS-2];
            end
          end
        end
        HOLD: begin
          if (rise_tick) begin
            ncs   <= 1'b1;
            copi  <= 1'b0;
            done  <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          // First strobe in GAP is a fall; the following rise closes the 2H gap.
          if (rise_tick) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench: table-driven writes on a CLK_DIV=4 instance plus corner sequences and a CLK_DIV=2 instance.
module tb_spi_reg_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CLK_DIV=4 instance
  logic       rst, req_valid, req_ready, sclk, copi, ncs, busy, done;
  logic [6:0] req_addr;
  logic [7:0] req_data;

  spi_reg_writer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .sclk(sclk), .copi(copi),
    .ncs(ncs), .busy(busy), .done(done)
  );

  // CLK_DIV=2 instance
  logic       rst_b, valid_b, ready_b, sclk_b, copi_b, ncs_b, busy_b, done_b;
  logic [6:0] addr_b;
  logic [7:0] data_b;

  spi_reg_writer #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_ready(ready_b),
    .req_addr(addr_b), .req_data(data_b), .sclk(sclk_b), .copi(copi_b),
    .ncs(ncs_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Mode-0 monitor for the CLK_DIV=4 instance
  int hs_cnt = 0, last_hs = 0, prev_hs = 0, done_cnt = 0, last_done = 0, last_ready = 0;
  int nb = 0, low = 0, high_run = 0, last_high_run = 0, rise_total = 0;
  int last_bits = 0, last_low = 0;
  logic [15:0] acc = '0;
  logic [15:0] frames_q[$];
  logic p_ncs = 1'b1, p_sclk = 1'b0, p_ready = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      acc = '0; nb = 0; low = 0;
      p_ncs = 1'b1; p_sclk = 1'b0; p_ready = 1'b1;
    end else begin
      if (req_valid && req_ready) begin prev_hs = last_hs; last_hs = cyc; hs_cnt++; end
      if (sclk && !p_sclk) rise_total++;
      if (!ncs) begin
        low++;
        if (sclk && !p_sclk) begin acc = {acc[14:0], copi}; nb++; end
      end
      if (!ncs && p_ncs) last_high_run = high_run;
      if (ncs && !p_ncs) begin
        frames_q.push_back(acc);
        last_bits = nb; last_low = low;
        acc = '0; nb = 0; low = 0; high_run = 0;
      end
      if (ncs) high_run++;
      if (done) begin done_cnt++; last_done = cyc; end
      if (req_ready && !p_ready) last_ready = cyc;
      p_ncs = ncs; p_sclk = sclk; p_ready = req_ready;
    end
  end

  // Monitor for the CLK_DIV=2 instance
  int hs2 = 0, done2_cyc = 0, done2_cnt = 0, nb2 = 0, last_rise2 = 0, period2 = 0, bits2 = 0;
  logic [15:0] acc2 = '0, frame2 = '0;
  logic p_sclk2 = 1'b0, p_ncs2 = 1'b1;

  always @(negedge clk) begin
    if (valid_b && ready_b) hs2 = cyc;
    if (!ncs_b && sclk_b && !p_sclk2) begin
      acc2 = {acc2[14:0], copi_b};
      nb2++;
      if (nb2 == 2) period2 = cyc - last_rise2;
      last_rise2 = cyc;
    end
    if (ncs_b && !p_ncs2) begin frame2 = acc2; bits2 = nb2; nb2 = 0; end
    if (done_b) begin done2_cnt++; done2_cyc = cyc; end
    p_sclk2 = sclk_b; p_ncs2 = ncs_b;
  end

  function automatic logic [15:0] frame_back(input int back);
    if (frames_q.size() > back) return frames_q[frames_q.size() - 1 - back];
    return 16'h0000;
  endfunction

  task automatic write4(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_data = d;
    @(negedge clk);
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
    if (!req_ready) check("handshake_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_frame4(input int d0);
    int n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(done_cnt > d0 && req_ready) && n < 600);
    if (n >= 600) check("frame_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, d0, h0, f0, r0, bad;
    logic [6:0] ra;
    logic [7:0] rd;

    vecs[0] = '{7'h00, 8'hFF, 16'h80FF};
    vecs[1] = '{7'h04, 8'h80, 16'h8480};
    vecs[2] = '{7'h55, 8'hAA, 16'hD5AA};
    vecs[3] = '{7'h7F, 8'h00, 16'hFF00};
    vecs[4] = '{7'h2A, 8'h3C, 16'hAA3C};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    rst_b = 1'b1; valid_b = 1'b0; addr_b = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({req_ready, busy, done, ncs, sclk, copi}), 32'(6'b100100));

    // Table-driven single writes
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      write4(vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check("cycle1_ready_busy_ncs", 32'({req_ready, busy, ncs}), 32'(3'b010));
      wait_frame4(d0);
      check("frame", 32'(frame_back(0)), 32'(vecs[i].frame));
      check("rise_count", 32'(last_bits), 32'(16));
      check("ncs_low_cycles", 32'(last_low), 32'(132));
      check("done_cycle", 32'(last_done - last_hs), 32'(133));
      check("ready_cycle", 32'(last_ready - last_hs), 32'(141));
    end

    // Back-to-back with req_valid held high
    h0 = hs_cnt; f0 = frames_q.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 7'h04; req_data = 8'h80;
    n = 0;
    while (hs_cnt < h0 + 2 && n < 600) begin @(negedge clk); #1; n++; end
    if (n >= 600) check("b2b_hs_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_hs_spacing", 32'(last_hs - prev_hs), 32'(141));
    wait_frame4(done_cnt);
    repeat (200) @(negedge clk);
    #1;
    check("b2b_frame_count", 32'(frames_q.size() - f0), 32'(2));
    check("b2b_hs_count", 32'(hs_cnt - h0), 32'(2));
    check("b2b_frame1", 32'(frame_back(1)), 32'(16'h8480));
    check("b2b_frame2", 32'(frame_back(0)), 32'(16'h8480));
    check("b2b_ncs_gap_ge8", 32'(last_high_run >= 8), 32'(1));

    // CLK_DIV=2 instance
    @(posedge clk); #1;
    valid_b = 1'b1; addr_b = 7'h7F; data_b = 8'h5A;
    @(negedge clk);
    n = 0;
    while (!ready_b && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    valid_b = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 300) begin @(negedge clk); #1; n++; end
    repeat (10) @(negedge clk);
    #1;
    check("div2_frame", 32'(frame2), 32'(16'hFF5A));
    check("div2_rise_count", 32'(bits2), 32'(16));
    check("div2_done_cycle", 32'(done2_cyc - hs2), 32'(67));
    check("div2_sclk_period", 32'(period2), 32'(4));

    // Reset after the 7th rising edge
    d0 = done_cnt; f0 = frames_q.size();
    write4(7'h12, 8'h34);
    n = 0;
    while (nb < 7 && n < 400) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 32'({req_ready, busy, done, ncs, sclk, copi}), 32'(6'b100100));
    repeat (60) @(negedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'(0));
    check("midrst_no_frame", 32'(frames_q.size() - f0), 32'(0));
    d0 = done_cnt;
    write4(7'h01, 8'h33);
    wait_frame4(d0);
    check("post_rst_frame", 32'(frame_back(0)), 32'(16'h8133));
    check("post_rst_rise_count", 32'(last_bits), 32'(16));

    // Scramble addr/data while busy
    ra = 7'($urandom); rd = 8'($urandom);
    d0 = done_cnt; r0 = rise_total;
    write4(ra, rd);
    repeat (150) begin
      @(posedge clk); #1;
      if (busy) begin req_addr = 7'($urandom); req_data = 8'($urandom); end
    end
    wait_frame4(d0);
    check("scramble_frame", 32'(frame_back(0)), 32'({1'b1, ra, rd}));
    check("scramble_rise_total", 32'(rise_total - r0), 32'(16));
    check("scramble_ncs_low", 32'(last_low), 32'(132));

    // Idle quiet
    bad = 0; h0 = hs_cnt;
    repeat (100) begin
      @(negedge clk);
      if (!(ncs && !sclk && !done)) bad++;
    end
    check("idle_quiet", 32'(bad), 32'(0));
    check("idle_no_handshake", 32'(hs_cnt - h0), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_reg_writer.md
# spi_reg_writer

SPI controller that drives register-write frames into the chip's SPI register peripheral (the block feeding the PWM enable and duty-cycle registers). It accepts one address/data write at a time over a valid/ready request port, serialises it as a 16-bit mode-0 SPI frame on sclk/copi/ncs, and pulses `done` when the frame completes. It is used as the on-chip or test-harness initiator for register configuration.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 2..255.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  7  register address.
- `req_data`  in  8  register write data.
- `sclk`  out  1  SPI clock, idle low (mode 0).
- `copi`  out  1  SPI controller-out data, MSB first.
- `ncs`  out  1  SPI chip select, active low.
- `busy`  out  1  high from handshake until `req_ready` returns.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- Frame (16 bits, MSB first): bit15 = 1 (write), bits14:8 = `req_addr`, bits7:0 = `req_data`.
- Handshake: transfer occurs on a cycle with `req_valid && req_ready`; addr/data are latched then. `req_valid` while not ready is ignored and never queued.
- States:
  - IDLE: `req_ready`=1, `ncs`=1, `sclk`=0, `copi`=0. Handshake -> SETUP.
  - SETUP: `ncs`=0, `copi`=bit15; after H=`CLK_DIV` cycles -> SHIFT.
  - SHIFT: `sclk` toggles every H cycles, 16 rising and 16 falling edges. `copi` updates to the next bit on each falling edge except the 16th. After the 16th falling edge -> HOLD.
  - HOLD: `sclk`=0, `copi` keeps bit0, for H cycles, then `ncs`=1, `done`=1 for one cycle -> GAP.
  - GAP: `ncs`=1 for 2H cycles total (counted from `ncs` rising), then -> IDLE.
- Counters: half-period counter of width clog2(`CLK_DIV`+1), wraps at `CLK_DIV`-1; edge counter 0..31 (5 bits); 16-bit shift register shifting left.
- `busy` = not IDLE.
- Reset, including mid-frame: next cycle `ncs`=1, `sclk`=0, `copi`=0, `done`=0, `busy`=0, `req_ready`=1, state IDLE; the in-flight frame is discarded and `done` is not pulsed.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `done`=0, `ncs`=1, `sclk`=0, `copi`=0.
- Handshake in cycle 0; `req_ready`=0 and `ncs`=0 from cycle 1.
- Rising edge k (k=1..16) at cycle 1+(2k-1)H; falling edge k at cycle 1+2kH.
- `ncs` rises and `done` pulses at cycle 1+33H.
- `req_ready` reasserts at cycle 1+35H; minimum request-to-request period is 35H+1 cycles.
- `copi` is stable at least H cycles around every rising `sclk`.
- All outputs are registered (no combinational paths from inputs to outputs).

## Structure
- Shared package `spi_pkg`:
  - `FRAME_BITS`=16
  - `WRITE_BIT`=1'b1
  - `ADDR_W`=7, `DATA_W`=8
  - state typedef {IDLE, SETUP, SHIFT, HOLD, GAP}
- One sub-module, `spi_sclk_gen`: half-period counter producing one-cycle `rise_tick`/`fall_tick` strobes, with enable and clear. The FSM, shift register and edge counter stay in `spi_reg_writer`.

## Test plan
- Single write, `CLK_DIV`=4, addr 0x00, data 0xFF: an SPI-mode-0 monitor samples `copi` on rising `sclk` and captures 0x80FF. `ncs` is low for exactly 132 cycles, `done` pulses once at cycle 133, and `req_ready` returns at cycle 141.
- Write addr 0x04, data 0x80 with `req_valid` held high continuously for two frames: two frames captured as 0x8480 each; `ncs` high ≥8 cycles between them; second handshake at cycle 141; no third frame.
- `CLK_DIV`=2, addr 0x7F, data 0x5A: frame 0xFF5A; `sclk` period 4 cycles; `done` at cycle 67.
- `rst` asserted for one cycle after the 7th rising edge: next cycle `ncs`=1, `sclk`=0, `copi`=0, `req_ready`=1; no `done` pulse; a subsequent write of addr 0x01, data 0x33 captures 0x8133 cleanly.
- Change `req_addr`/`req_data` randomly while `busy`: the captured frame equals the values at the handshake, and no extra `sclk` edges occur.
- Idle for 100 cycles with `req_valid`=0: `ncs`=1, `sclk`=0, `done`=0 throughout.
